// File: rtl/dcm_reset_seq_if.sv
// Signal bundle between the DCM reset sequencer, the DCM it drives and the
// logic clocked from the DCM outputs.
interface dcm_reset_seq_if;
  logic       locked;
  logic       dcm_reset;
  logic       reset_o;
  logic       ready;
  logic [7:0] retries;

  modport master (
    input  locked,
    output dcm_reset,
    output reset_o,
    output ready,
    output retries
  );

  modport slave (
    output locked,
    input  dcm_reset,
    input  reset_o,
    input  ready,
    input  retries
  );
endinterface

// File: rtl/dcm_reset_seq.sv
// DCM reset sequencer: pulses the DCM reset, waits for a stable lock, then
// releases the system reset; re-pulses on lock timeout or lock loss.
module dcm_reset_seq #(
  parameter int unsigned DCMRST_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic            clock,
  input  logic            reset,
  dcm_reset_seq_if.master bus
);

  typedef enum logic [1:0] {
    ST_DCMRST   = 2'd0,
    ST_WAITLOCK = 2'd1,
    ST_STABLE   = 2'd2,
    ST_RUN      = 2'd3
  } state_t;

  localparam logic [15:0] DCMRST_LAST = 16'(DCMRST_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);

  logic        sync_meta;
  logic        locked_s;
  state_t      state;
  state_t      state_next;
  logic [15:0] count;
  logic [15:0] count_next;
  logic [7:0]  retries;
  logic [7:0]  retries_next;
  logic        retry_event;
  logic        dcm_reset_q;
  logic        reset_o_q;
  logic        ready_q;

  // locked comes from the DCM and is asynchronous to clock
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      sync_meta <= bus.locked;
      locked_s  <= sync_meta;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state and never see a combinational path from locked.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_DCMRST;
      count       <= '0;
      retries     <= '0;
      dcm_reset_q <= 1'b1;
      reset_o_q   <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      retries     <= retries_next;
      dcm_reset_q <= (state_next == ST_DCMRST);
      reset_o_q   <= (state_next != ST_RUN);
      ready_q     <= (state_next == ST_RUN);
    end
  end

  always_comb begin
    state_next  = state;
    retry_event = 1'b0;
    case (state)
      ST_DCMRST: begin
        if (count == DCMRST_LAST) state_next = ST_WAITLOCK;
      end
      ST_WAITLOCK: begin
        if (locked_s) begin
          state_next = ST_STABLE;
        end else if (count == LOCK_LAST) begin
          state_next  = ST_DCMRST;
          retry_event = 1'b1;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_next = ST_WAITLOCK;
        end else if (count == STABLE_LAST) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_next  = ST_DCMRST;
          retry_event = 1'b1;
        end
      end
      default: state_next = ST_DCMRST;
    endcase

    // The count may wrap while sitting in RUN; nothing there looks at it.
    count_next   = (state_next != state) ? 16'd0 : count + 16'd1;
    retries_next = (retry_event && (retries != 8'hFF)) ? retries + 8'd1 : retries;
  end

  assign bus.dcm_reset = dcm_reset_q;
  assign bus.reset_o   = reset_o_q;
  assign bus.ready     = ready_q;
  assign bus.retries   = retries;

endmodule

// File: tb/tb_dcm_reset_seq.sv
// Directed testbench for dcm_reset_seq with short timing parameters
// (4-cycle DCM reset, 16-cycle lock timeout, 8-cycle stable window).
module tb_dcm_reset_seq;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  dcm_reset_seq_if bus ();

  dcm_reset_seq #(
    .DCMRST_CYCLES(4),
    .LOCK_TIMEOUT (16),
    .STABLE_CYCLES(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Inputs change 1 time unit after a rising edge, i.e. between edges
  task automatic applyStimulus(input logic rstVal, input logic lockVal);
    reset      = rstVal;
    bus.locked = lockVal;
  endtask

  task automatic waitEdges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic expDcm, input logic expRst,
                             input logic expRdy, input logic [7:0] expRetries);
    checks++;
    assert (bus.dcm_reset === expDcm) else begin
      errors++;
      $error("[TB] FAIL %s dcm_reset got %b want %b", tag, bus.dcm_reset, expDcm);
    end
    checks++;
    assert (bus.reset_o === expRst) else begin
      errors++;
      $error("[TB] FAIL %s reset_o got %b want %b", tag, bus.reset_o, expRst);
    end
    checks++;
    assert (bus.ready === expRdy) else begin
      errors++;
      $error("[TB] FAIL %s ready got %b want %b", tag, bus.ready, expRdy);
    end
    checks++;
    assert (bus.retries === expRetries) else begin
      errors++;
      $error("[TB] FAIL %s retries got %0d want %0d", tag, bus.retries, expRetries);
    end
  endtask

  // Holds reset for one edge, then releases it between edges so the next
  // rising edge is cycle 1 of DCMRST.
  task automatic startFresh(input logic lockVal);
    applyStimulus(1'b1, lockVal);
    waitEdges(1);
    applyStimulus(1'b0, lockVal);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    applyStimulus(1'b1, 1'b0);
    #2;
    checkOutput("reset_initial", 1'b1, 1'b1, 1'b0, 8'd0);
    waitEdges(2);
    checkOutput("reset_held", 1'b1, 1'b1, 1'b0, 8'd0);

    // Nominal: locked rises between edges 3 and 4, ready at edge 14
    applyStimulus(1'b0, 1'b0);
    waitEdges(1);
    checkOutput("nom_e1", 1'b1, 1'b1, 1'b0, 8'd0);
    waitEdges(2);
    checkOutput("nom_e3", 1'b1, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1);
    waitEdges(1);
    checkOutput("nom_e4", 1'b0, 1'b1, 1'b0, 8'd0);
    waitEdges(9);
    checkOutput("nom_e13", 1'b0, 1'b1, 1'b0, 8'd0);
    waitEdges(1);
    checkOutput("nom_e14", 1'b0, 1'b0, 1'b1, 8'd0);

    // Lock loss in RUN: outputs react on the 3rd edge after locked falls
    applyStimulus(1'b0, 1'b0);
    waitEdges(2);
    checkOutput("loss_e2", 1'b0, 1'b0, 1'b1, 8'd0);
    waitEdges(1);
    checkOutput("loss_e3", 1'b1, 1'b1, 1'b0, 8'd1);
    waitEdges(3);
    checkOutput("loss_dcmrst_end", 1'b1, 1'b1, 1'b0, 8'd1);
    applyStimulus(1'b0, 1'b1);
    waitEdges(1);
    checkOutput("loss_waitlock", 1'b0, 1'b1, 1'b0, 8'd1);
    waitEdges(9);
    checkOutput("loss_prerun", 1'b0, 1'b1, 1'b0, 8'd1);
    waitEdges(1);
    checkOutput("loss_run", 1'b0, 1'b0, 1'b1, 8'd1);

    // Asynchronous reset from RUN, checked before the next edge
    #1;
    applyStimulus(1'b1, 1'b1);
    #1;
    checkOutput("async_from_run", 1'b1, 1'b1, 1'b0, 8'd0);

    // Lock glitch during STABLE: back to WAITLOCK without a DCM pulse
    waitEdges(1);
    applyStimulus(1'b0, 1'b1);
    waitEdges(4);
    checkOutput("glitch_e4", 1'b0, 1'b1, 1'b0, 8'd0);
    waitEdges(2);
    applyStimulus(1'b0, 1'b0);
    waitEdges(1);
    applyStimulus(1'b0, 1'b1);
    waitEdges(2);
    checkOutput("glitch_e9", 1'b0, 1'b1, 1'b0, 8'd0);
    waitEdges(4);
    checkOutput("glitch_e13", 1'b0, 1'b1, 1'b0, 8'd0);
    waitEdges(4);
    checkOutput("glitch_e17", 1'b0, 1'b1, 1'b0, 8'd0);
    waitEdges(1);
    checkOutput("glitch_e18", 1'b0, 1'b0, 1'b1, 8'd0);

    // Timeout: locked stays low, DCM reset repeats every 20 edges
    startFresh(1'b0);
    waitEdges(4);
    checkOutput("to_e4", 1'b0, 1'b1, 1'b0, 8'd0);
    waitEdges(15);
    checkOutput("to_e19", 1'b0, 1'b1, 1'b0, 8'd0);
    waitEdges(1);
    checkOutput("to_e20", 1'b1, 1'b1, 1'b0, 8'd1);
    waitEdges(3);
    checkOutput("to_e23", 1'b1, 1'b1, 1'b0, 8'd1);
    waitEdges(1);
    checkOutput("to_e24", 1'b0, 1'b1, 1'b0, 8'd1);
    waitEdges(15);
    checkOutput("to_e39", 1'b0, 1'b1, 1'b0, 8'd1);
    waitEdges(1);
    checkOutput("to_e40", 1'b1, 1'b1, 1'b0, 8'd2);

    // Lock seen on the very edge the timeout would fire: lock wins
    waitEdges(17);
    applyStimulus(1'b0, 1'b1);
    waitEdges(2);
    checkOutput("prio_e59", 1'b0, 1'b1, 1'b0, 8'd2);
    waitEdges(1);
    checkOutput("prio_e60", 1'b0, 1'b1, 1'b0, 8'd2);
    waitEdges(7);
    checkOutput("prio_e67", 1'b0, 1'b1, 1'b0, 8'd2);
    waitEdges(1);
    checkOutput("prio_e68", 1'b0, 1'b0, 1'b1, 8'd2);

    // Saturation: 300 timeouts, retries sticks at 255
    startFresh(1'b0);
    waitEdges(5099);
    checkOutput("sat_e5099", 1'b0, 1'b1, 1'b0, 8'd254);
    waitEdges(1);
    checkOutput("sat_e5100", 1'b1, 1'b1, 1'b0, 8'd255);
    waitEdges(20);
    checkOutput("sat_e5120", 1'b1, 1'b1, 1'b0, 8'd255);
    waitEdges(880);
    checkOutput("sat_e6000", 1'b1, 1'b1, 1'b0, 8'd255);
    waitEdges(4);
    checkOutput("sat_e6004", 1'b0, 1'b1, 1'b0, 8'd255);

    // Asynchronous reset from WAITLOCK clears the saturated counter
    #1;
    applyStimulus(1'b1, 1'b0);
    #1;
    checkOutput("async_from_wait", 1'b1, 1'b1, 1'b0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcm_reset_seq.md
DCM_RESET_SEQ -- requirements
Module: dcm_reset_seq

Interface
REQ-001 Parameter DCMRST_CYCLES, default 8: number of clock cycles dcm_reset is held high per DCM reset pulse; legal range 3..65535.
REQ-002 Parameter LOCK_TIMEOUT, default 65535: number of cycles to wait for lock before re-pulsing DCM reset; legal range 1..65535.
REQ-003 Parameter STABLE_CYCLES, default 1024: number of cycles lock must hold continuously before system reset is released; legal range 1..65535.
REQ-004 Port clock, input, 1 bit: single clock, the DCM input clock domain; all flops SHALL be rising-edge triggered on clock.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port locked, input, 1 bit: DCM lock indication, asynchronous to clock.
REQ-007 Port dcm_reset, output, 1 bit: reset to the DCM RST pin, active high.
REQ-008 Port reset_o, output, 1 bit: system reset for logic clocked from the DCM outputs, active high.
REQ-009 Port ready, output, 1 bit: high only while in RUN; always equal to the inverse of reset_o.
REQ-010 Port retries, output, 8 bits: count of lock timeouts plus lock losses, saturating at 255.

Function
REQ-011 locked SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the synchronized value locked_s, which lags locked by 2 edges.
REQ-012 The FSM SHALL have exactly four states: DCMRST, WAITLOCK, STABLE and RUN.
REQ-013 A 16-bit counter SHALL clear on every state transition and increment by 1 on each edge spent in the same state.
REQ-014 In DCMRST, the FSM SHALL move to WAITLOCK on the edge where counter == DCMRST_CYCLES-1, so DCMRST lasts exactly DCMRST_CYCLES cycles.
REQ-015 In WAITLOCK, the FSM SHALL move to STABLE if locked_s=1; otherwise it SHALL move to DCMRST and increment retries on the edge where counter == LOCK_TIMEOUT-1; locked_s=1 SHALL take priority on that edge.
REQ-016 In STABLE, the FSM SHALL return to WAITLOCK (counter cleared, no DCM reset) if locked_s=0; otherwise it SHALL move to RUN on the edge where counter == STABLE_CYCLES-1; locked_s=0 SHALL take priority.
REQ-017 In RUN, the FSM SHALL move to DCMRST and increment retries when locked_s=0; the counter is don't-care in RUN and SHALL NOT wrap into any action.
REQ-018 Outputs SHALL be registered (decoded from next state): dcm_reset=1 exactly while state==DCMRST, reset_o=1 while state!=RUN, and ready=1 while state==RUN.
REQ-019 reset_o SHALL assert on the same edge the FSM leaves RUN, i.e. 3 edges after locked falls.
REQ-020 retries SHALL hold at 255 on further increment events, and SHALL NOT clear except by reset.
REQ-021 Nominal time from reset release to ready=1 SHALL be DCMRST_CYCLES + (cycles until locked) + 2 + STABLE_CYCLES edges.
REQ-022 The outputs SHALL be glitch-free, with no combinational path from locked to any output.

Reset
REQ-023 On reset=1, asynchronously and immediately: state=DCMRST, counter=0, synchronizer flops=0, retries=0, dcm_reset=1, reset_o=1, ready=0.
REQ-024 Assertion of reset mid-operation (any state) SHALL produce the REQ-023 values with no dependence on the clock.
REQ-025 After reset deasserts, the first rising edge SHALL count as cycle 1 of DCMRST.

Verification (DCMRST_CYCLES=4, LOCK_TIMEOUT=16, STABLE_CYCLES=8)
REQ-026 Scenario nominal: release reset, raise locked before edge 4 -> dcm_reset high for edges 1-4, ready rises at edge 14, retries=0.
REQ-027 Scenario timeout: locked held 0 -> dcm_reset pulses 4 cycles, then 16 low, repeating; retries increments on each pulse start.
REQ-028 Scenario lock glitch in STABLE: locked=0 for 1 cycle during STABLE -> return to WAITLOCK, no dcm_reset pulse; ready is delayed by a full 8 cycles after relock.
REQ-029 Scenario lock loss in RUN: drop locked -> reset_o=1 and dcm_reset=1 at the 3rd edge, retries+1, then the nominal sequence resumes.
REQ-030 Scenario saturation and async reset: force 300 timeouts -> retries=255; assert reset between edges -> all outputs take reset values before the next edge.
